// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: frame geometry, transmitter states and the baud divisor rounding rule.
package uart_tx_fifo_pkg;

    localparam int DATA_BITS    = 8;
    localparam int DEFAULT_BAUD = 115_200;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    // Clocks per bit, rounded to nearest so TX and RX derive the same value.
    function automatic int baud_div(input int clk_fq, input int baud);
        return (clk_fq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous reset; head word is always on rd_data.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr && !reset) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_wr && !do_rd) begin
                level <= level + (AW + 1)'(1);
            end else if (do_rd && !do_wr) begin
                level <= level - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter, LSB first; frames go out back-to-back while the FIFO holds data.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLK_FQ     = 128_000_000,
    parameter int BAUD       = DEFAULT_BAUD,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        aclk,
    input  logic                        reset,
    input  logic [7:0]                  s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int DIV = baud_div(CLK_FQ, BAUD);
    localparam int CW  = $clog2(DIV);
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(DIV - 1);
    localparam logic [2:0]    LAST_BIT    = 3'(DATA_BITS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo: CLK_FQ/BAUD must give at least 2 clocks per bit");
    end

    tx_state_t     state, state_nxt;
    logic [CW-1:0] baud_cnt, baud_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          tx_nxt;
    logic          busy_nxt;
    logic          pop;
    logic          wr;
    logic [7:0]    fifo_rd_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] level_nxt;

    assign s_ready = !reset && !fifo_full;
    assign wr      = s_valid && s_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .reset   (reset),
        .wr_en   (wr),
        .wr_data (s_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        tx_nxt    = tx;
        pop       = 1'b0;
        if (baud_cnt != '0) begin
            baud_nxt = baud_cnt - CW'(1);
        end
        case (state)
            ST_IDLE: begin
                tx_nxt = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_nxt = fifo_rd_data;
                    tx_nxt    = 1'b0;
                    baud_nxt  = BAUD_RELOAD;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (baud_cnt == '0) begin
                    tx_nxt    = shift[0];
                    bit_nxt   = '0;
                    baud_nxt  = BAUD_RELOAD;
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_cnt == '0) begin
                    baud_nxt = BAUD_RELOAD;
                    if (bit_idx == LAST_BIT) begin
                        tx_nxt    = 1'b1;
                        state_nxt = ST_STOP;
                    end else begin
                        shift_nxt = {1'b0, shift[7:1]};
                        tx_nxt    = shift[1];
                        bit_nxt   = bit_idx + 3'(1);
                    end
                end
            end
            ST_STOP: begin
                if (baud_cnt == '0) begin
                    // Chaining straight into the next start bit keeps frames gap-free.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_nxt = fifo_rd_data;
                        tx_nxt    = 1'b0;
                        baud_nxt  = BAUD_RELOAD;
                        state_nxt = ST_START;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        level_nxt = fifo_level + LW'(wr) - LW'(pop);
        busy_nxt  = (state_nxt != ST_IDLE) || (level_nxt != '0);
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
            tx       <= tx_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule
